// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit accumulator CPU: opcodes, sequencer states
// and instruction field positions.
package cpu_pkg;

    localparam int I_BIT    = 7;
    localparam int OP_MSB   = 6;
    localparam int OP_LSB   = 4;
    localparam int ADDR_MSB = 3;
    localparam int ADDR_LSB = 0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    // The numeric values are visible on the sc port, so they are fixed.
    typedef enum logic [2:0] {
        ST_FETCH0   = 3'd0,
        ST_FETCH1   = 3'd1,
        ST_DECODE   = 3'd2,
        ST_INDIRECT = 3'd3,
        ST_OPERAND  = 3'd4,
        ST_EXECUTE  = 3'd5,
        ST_HALT     = 3'd6,
        ST_IDLE     = 3'd7
    } state_t;

    // Register-only and jump instructions go straight from INDIRECT to EXECUTE.
    function automatic logic skips_operand(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_CMP) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute control stage of the accumulator CPU: owns PC, AR, IR,
// DR, AC and E, walks the state sequence and writes ALU results back into AC.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        alu_sel,
    output logic [DATA_W-1:0] alu_ac,
    output logic [DATA_W-1:0] alu_dr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_e,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ac,
    output logic              e_flag,
    output logic [2:0]        sc,
    output logic              instr_done,
    output logic              halted
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] ar_reg;
    logic [DATA_W-1:0] ir_reg;
    logic [DATA_W-1:0] dr_reg;
    logic [DATA_W-1:0] ac_reg;
    logic              e_reg;
    logic [2:0]        opcode;

    assign opcode = ir_reg[OP_MSB:OP_LSB];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (start) state_next = ST_FETCH0;
            ST_FETCH0:   state_next = ST_FETCH1;
            ST_FETCH1:   state_next = ST_DECODE;
            ST_DECODE:   state_next = (opcode == OP_HLT) ? ST_HALT : ST_INDIRECT;
            ST_INDIRECT: state_next = skips_operand(opcode) ? ST_EXECUTE : ST_OPERAND;
            ST_OPERAND:  state_next = ST_EXECUTE;
            ST_EXECUTE:  state_next = ST_FETCH0;
            ST_HALT:     state_next = ST_HALT;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sc         = state_reg;
        instr_done = (state_reg == ST_EXECUTE);
        halted     = (state_reg == ST_HALT);
        mem_addr   = ar_reg;
        alu_sel    = opcode;
        alu_ac     = ac_reg;
        alu_dr     = dr_reg;
        pc         = pc_reg;
        ac         = ac_reg;
        e_flag     = e_reg;
    end

    // Reset wins over everything, so an interrupted instruction leaves no trace.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_reg <= RESET_PC;
            ar_reg <= '0;
            ir_reg <= '0;
            dr_reg <= '0;
            ac_reg <= '0;
            e_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH0: ar_reg <= pc_reg;
                ST_FETCH1: begin
                    ir_reg <= mem_rdata;
                    pc_reg <= pc_reg + ADDR_W'(1);
                end
                ST_DECODE: ar_reg <= ir_reg[ADDR_MSB:ADDR_LSB];
                ST_INDIRECT: begin
                    if (ir_reg[I_BIT]) ar_reg <= mem_rdata[ADDR_MSB:ADDR_LSB];
                end
                ST_OPERAND: dr_reg <= mem_rdata;
                ST_EXECUTE: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_SHL: begin
                            ac_reg <= alu_result;
                            e_reg  <= alu_e;
                        end
                        OP_XOR, OP_CMP: ac_reg <= alu_result;
                        OP_LDA:         ac_reg <= dr_reg;
                        OP_JMP:         pc_reg <= ar_reg;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/execute control stage of the 8-bit accumulator CPU, directly upstream of the ALU.
- Owns PC, AR, IR, DR, AC, the E flag and the sequence counter SC.
- Reads instructions and operands from the 16x8 program memory, resolves indirect addressing, presents AC/DR/selector to the ALU, and writes the ALU result back into AC.

Parameters:
- ADDR_W, 4, memory address / PC / AR width (16 words)
- DATA_W, 8, instruction, data and accumulator width
- RESET_PC, 0, PC value loaded on reset

Ports:
- CLK  input  1  sole clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- start  input  1  begins execution when in IDLE; ignored elsewhere
- mem_addr  output  ADDR_W  program memory read address
- mem_rdata  input  DATA_W  combinational read data for mem_addr, valid in the same cycle
- alu_sel  output  3  ALU selector, equal to IR[6:4]
- alu_ac  output  DATA_W  current AC
- alu_dr  output  DATA_W  current DR
- alu_result  input  DATA_W  combinational ALU result
- alu_e  input  1  ALU carry/borrow out
- pc  output  ADDR_W  program counter
- ac  output  DATA_W  accumulator
- e_flag  output  1  latched carry flag
- sc  output  3  current state encoding
- instr_done  output  1  high for exactly one cycle, during EXECUTE
- halted  output  1  high while in HALT

Behaviour:
- Instruction format: IR[7] = I (indirect), IR[6:4] = opcode, IR[3:0] = address.
- Opcodes:
  - 000 ADD, 001 SUB, 010 XOR: AC <= alu_result; 000/001 also latch E <= alu_e.
  - 011 SHL: AC+AC, no operand fetch, latch E.
  - 100 LDA: AC <= DR.
  - 101 JMP: PC <= AR.
  - 110 CMP: ~AC, no operand fetch.
  - 111 HLT.
- Reset: state IDLE (sc=7), PC=RESET_PC, AR=0, IR=0, DR=0, AC=0, E=0, instr_done=0, halted=0. RST has priority over every other input in every state, including mid-instruction; no partial writeback may survive it.
- mem_addr = AR in all states.
- States (sc encoding) and transitions:
  - IDLE (7): start=1 -> FETCH0.
  - FETCH0 (0): AR <= PC.
  - FETCH1 (1): IR <= mem_rdata; PC <= PC+1, wrapping 15->0.
  - DECODE (2): AR <= IR[3:0]. Opcode 111 -> HALT; otherwise -> INDIRECT.
  - INDIRECT (3): if I=1, AR <= mem_rdata[3:0]; I=0 is a one-cycle no-op. Then opcodes 011/110/101 -> EXECUTE; all others -> OPERAND.
  - OPERAND (4): DR <= mem_rdata.
  - EXECUTE (5): writeback per opcode; instr_done=1; -> FETCH0.
  - HALT (6): terminal until RST; start ignored; halted=1.
- Latency:
  - Memory-reference instructions (000/001/010/100): 6 cycles.
  - 011/110/101: 5 cycles.
  - HLT: 3 cycles from FETCH0 to HALT.
- Width rules:
  - AC and ALU arithmetic are modulo 2^8; overflow is visible only through E.
  - E is unchanged by 010/100/101/110.
- alu_sel, alu_ac and alu_dr are driven continuously; the ALU result is consumed only in EXECUTE.
- start held high across instructions has no effect outside IDLE.
- JMP to the current PC forms a legal infinite loop.

Decomposition:
- Shared package cpu_pkg:
  - Opcode localparams: OP_ADD..OP_HLT.
  - State encodings: ST_FETCH0..ST_IDLE.
  - Field index constants: I_BIT, OP_MSB/LSB, ADDR_MSB/LSB.
- No sub-module required; the state register and datapath registers live in one module. pc_counter (wrapping ADDR_W incrementer) is an optional split.

Test Plan:
- Memory 0x48,0x09,0x9A,0x30,0x60,0x70 with [8]=0x05, [9]=0x03, [10]=0x0B, [11]=0x02; RST then start pulse -> AC sequence 05, 08, 06, 0C, F3; HALT reached with pc=6, halted=1; instr_done pulses at cycles 6, 12, 18, 23, 28 after start.
- ADD overflow: [0]=0x48, [8]=0xFF, [1]=0x09, [9]=0x01 -> AC=0x00, e_flag=1; next instruction CMP (0x60) -> AC=0xFF, e_flag still 1.
- PC wrap: [15]=0x30 (SHL) reached by [0]=0x5F (JMP 15), AC=0 -> after SHL pc=0; JMP costs 5 cycles.
- Indirect JMP: [0]=0xD4, [4]=0x07, [7]=0x70 -> pc=7 after JMP, then HALT with pc=8.
- Reset mid-instruction: assert RST in OPERAND of an ADD -> next cycle sc=7, AC=0, PC=0, DR=0, instr_done never pulses.
- HALT stickiness: in HALT drive start=1 for 10 cycles -> sc stays 6, pc/AC unchanged; RST -> sc=7.
